// File: rtl/simplez_pkg.sv
// Shared constants for the Simplez external memory bus and its peripherals.
package simplez_pkg;

  // Bus widths, matching the CPU's RA and AC/RI registers
  localparam int BUS_ADDRW = 9;
  localparam int BUS_DATAW = 12;

  // Peripheral base addresses on the external bus
  localparam logic [8:0] LEDS_ADDR    = 9'o100;
  localparam logic [8:0] UART_TX_ADDR = 9'o101;

  // Bit positions inside the UART STATUS word
  localparam int STATUS_READY   = 0;
  localparam int STATUS_BUSY    = 1;
  localparam int STATUS_OVERRUN = 2;

  // Serialiser frame phases
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/simplez_baud_gen.sv
// Bit-period counter: counts 0..CLKDIV-1 and pulses tick on the last count.
// reload forces the count back to 0 so every new phase starts a full period.
module simplez_baud_gen #(
  parameter int CLKDIV = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  output logic tick
);

  logic [11:0] count;

  assign tick = (count == 12'(CLKDIV - 1));

  // Free-running period counter, restarted on reload or at the end of a period
  always_ff @(negedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (reload || tick) begin
      count <= '0;
    end else begin
      count <= count + 12'd1;
    end
  end

endmodule

// File: rtl/simplez_uart_tx.sv
// Memory-mapped 8N1 serial transmitter on the Simplez external bus.
// TXDATA at BASE (write-only, reads 0), STATUS at BASE+1 ({overrun, busy, ready}).
// All state updates on the falling clock edge, like the CPU core.
// Build option SIMPLEZ_UART_TX_FIFO_EN: replaces the single holding register
// with a 4-entry FIFO; STATUS layout is unchanged.
module simplez_uart_tx
  import simplez_pkg::*;
#(
  parameter int               ADDRW  = BUS_ADDRW,
  parameter int               DATAW  = BUS_DATAW,
  parameter logic [ADDRW-1:0] BASE   = ADDRW'(UART_TX_ADDR),
  parameter int               CLKDIV = 104
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ADDRW-1:0] addr,
  input  logic             wr,
  input  logic             rd,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             hit,
  output logic             tx
);

  localparam logic [ADDRW-1:0] STATUS_ADDR = BASE + ADDRW'(1);

  tx_state_e  state, next_state;
  logic       sel_data, sel_status;
  logic       push, load, tick, reload;
  logic       ready, pending, busy, overrun, tx_d;
  logic [7:0] head, shift;
  logic [2:0] bit_idx;
  logic [DATAW-1:0] status_word;
  logic       unused_inputs;

  // Reads have no side effects and only the low byte is transmitted
  assign unused_inputs = ^{rd, data_in[DATAW-1:8]};

  assign sel_data   = (addr == BASE);
  assign sel_status = (addr == STATUS_ADDR);
  assign hit        = sel_data || sel_status;
  assign push       = wr && sel_data && ready;
  assign load       = pending && ((state == IDLE) || ((state == STOP) && tick));
  assign busy       = (state != IDLE) || pending;

  // STATUS word assembly and read mux; TXDATA and misses read as zero
  always_comb begin
    status_word                 = '0;
    status_word[STATUS_READY]   = ready;
    status_word[STATUS_BUSY]    = busy;
    status_word[STATUS_OVERRUN] = overrun;
    data_out                    = sel_status ? status_word : '0;
  end

`ifdef SIMPLEZ_UART_TX_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;

  assign ready   = (count < 3'd4);
  assign pending = (count != 3'd0);
  assign head    = fifo_mem[rd_ptr];

  // Circular buffer between the bus and the shifter; a pop and a push may share an edge
  always_ff @(negedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= data_in[7:0];
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (load) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      count <= count + {2'b00, push} - {2'b00, load};
    end
  end
`else
  logic       hold_full;
  logic [7:0] hold_data;

  assign ready   = !hold_full;
  assign pending = hold_full;
  assign head    = hold_data;

  // Single holding register; push only when empty and load only when full, so they never collide
  always_ff @(negedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (push) begin
      hold_full <= 1'b1;
      hold_data <= data_in[7:0];
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end
`endif

  // Sticky overrun: set by a rejected TXDATA write, cleared by any STATUS write
  always_ff @(negedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (wr && sel_data && !ready) begin
      overrun <= 1'b1;
    end else if (wr && sel_status) begin
      overrun <= 1'b0;
    end
  end

  // Hold the period counter at zero while idle and restart it on every phase change
  assign reload = (state == IDLE) || (next_state != state);

  simplez_baud_gen #(
    .CLKDIV (CLKDIV)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .reload (reload),
    .tick   (tick)
  );

  // Frame phase register
  always_ff @(negedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Phase sequencing; STOP chains straight into START when another byte waits
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pending) next_state = START;
      START:   if (tick) next_state = DATA;
      DATA:    if (tick && (bit_idx == 3'd7)) next_state = STOP;
      STOP:    if (tick) next_state = pending ? START : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Shift data and bit index; bytes go out LSB first
  always_ff @(negedge clk) begin
    if (rst) begin
      shift   <= '0;
      bit_idx <= '0;
    end else if (load) begin
      shift   <= head;
      bit_idx <= '0;
    end else if ((state == DATA) && tick) begin
      bit_idx <= bit_idx + 3'd1;
    end
  end

  // Line level for the current phase
  always_comb begin
    tx_d = 1'b1;
    case (state)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift[bit_idx];
      default: tx_d = 1'b1;
    endcase
  end

  // Registered line driver so tx is glitch-free; forced idle-high by reset
  always_ff @(negedge clk) begin
    if (rst) begin
      tx <= 1'b1;
    end else begin
      tx <= tx_d;
    end
  end

endmodule

// File: tb/tb_simplez_uart_tx.sv
// Self-checking bench for simplez_uart_tx with CLKDIV=4.
// Reference model: a byte queue of the buffer capacity plus the start edge of
// each frame; the expected line level is derived from frame position arithmetic.
module tb_simplez_uart_tx;

  localparam int         D    = 4;
  localparam logic [8:0] BASE = 9'o101;
  localparam logic [8:0] STAT = 9'o102;
  localparam logic [8:0] LEDS = 9'o100;
`ifdef SIMPLEZ_UART_TX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  addr = '0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [11:0] data_in = '0;
  logic [11:0] data_out;
  logic        hit;
  logic        tx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  simplez_uart_tx #(
    .ADDRW (9),
    .DATAW (12),
    .BASE  (BASE),
    .CLKDIV(D)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .wr      (wr),
    .rd      (rd),
    .data_in (data_in),
    .data_out(data_out),
    .hit     (hit),
    .tx      (tx)
  );

  // Reference model state
  int         n          = 0;
  int         frame_end  = -1000;
  int         cur_start  = -1000;
  int         prev_start = -1000;
  logic [7:0] cur_byte   = '0;
  logic [7:0] prev_byte  = '0;
  logic [7:0] pend_q[$];
  logic       ov     = 1'b0;
  logic       exp_tx = 1'b1;

  // Line level m edges into a frame that began at edge s
  function automatic logic frame_bit(int m, int s, logic [7:0] b);
    int idx;
    idx = (m - s) / D;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  function automatic logic line_at(int m);
    if (m >= cur_start && m < cur_start + 10 * D) return frame_bit(m, cur_start, cur_byte);
    if (m >= prev_start && m < prev_start + 10 * D) return frame_bit(m, prev_start, prev_byte);
    return 1'b1;
  endfunction

  function automatic logic [11:0] exp_dout(logic [8:0] a);
    logic busy_m, ready_m;
    busy_m  = (n < frame_end) || (pend_q.size() > 0);
    ready_m = (pend_q.size() < CAP);
    if (a == STAT) return {9'b0, ov, busy_m, ready_m};
    return 12'b0;
  endfunction

  // Advance the model by one active edge with the inputs the DUT sampled
  task automatic model_edge(input logic r, input logic [8:0] a, input logic w, input logic [11:0] d);
    logic ready_m;
    n++;
    if (r) begin
      pend_q.delete();
      frame_end  = -1000;
      cur_start  = -1000;
      prev_start = -1000;
      ov         = 1'b0;
    end else begin
      ready_m = (pend_q.size() < CAP);
      if (pend_q.size() > 0 && n >= frame_end) begin
        prev_start = cur_start;
        prev_byte  = cur_byte;
        cur_start  = n;
        cur_byte   = pend_q.pop_front();
        frame_end  = n + 10 * D;
      end
      if (w && a == BASE) begin
        if (ready_m) pend_q.push_back(d[7:0]);
        else ov = 1'b1;
      end
      if (w && a == STAT) ov = 1'b0;
    end
    exp_tx = line_at(n - 1);
  endtask

  task automatic applyStimulus(input logic r, input logic [8:0] a, input logic w, input logic [11:0] d);
    @(posedge clk);
    rst     = r;
    addr    = a;
    wr      = w;
    rd      = !w;
    data_in = d;
    @(negedge clk);
    model_edge(r, a, w, d);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, STAT, 1'b0, 12'o0);
    applyStimulus(1'b1, STAT, 1'b0, 12'o0);
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, STAT, 1'b0, 12'o0);
      if (tx !== exp_tx) begin errors++; $display("FAIL reset_idle_tx edge=%0d got=%b exp=%b", n, tx, exp_tx); end
      checks++;
    end
    if (data_out !== 12'o0001) begin errors++; $display("FAIL reset_status got=%o exp=0001", data_out); end
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL reset_hit got=%b exp=1", hit); end
    checks++;
  endtask

  task automatic test_frame(input logic [11:0] val);
    int low_cnt;
    low_cnt = 0;
    applyStimulus(1'b0, BASE, 1'b1, val);
    for (int k = 1; k <= 44; k++) begin
      applyStimulus(1'b0, STAT, 1'b0, 12'o0);
      if (tx === 1'b0) low_cnt++;
      if (tx !== exp_tx) begin errors++; $display("FAIL frame_tx val=%o edge=%0d got=%b exp=%b", val, n, tx, exp_tx); end
      checks++;
      if (data_out !== exp_dout(addr)) begin
        errors++; $display("FAIL frame_status val=%o edge=%0d got=%o exp=%o", val, n, data_out, exp_dout(addr));
      end
      checks++;
      if (k == 2 && tx !== 1'b0) begin errors++; $display("FAIL frame_latency got=%b exp=0", tx); end
      if (k == 2) checks++;
    end
    if (data_out !== 12'o0001) begin errors++; $display("FAIL frame_drained got=%o exp=0001", data_out); end
    checks++;
    if (val == 12'o7777) begin
      if (low_cnt !== D) begin errors++; $display("FAIL frame_ff_lowcycles got=%0d exp=%0d", low_cnt, D); end
      checks++;
    end
  endtask

  task automatic test_overrun();
    applyStimulus(1'b0, BASE, 1'b1, 12'h041);
    applyStimulus(1'b0, STAT, 1'b0, 12'o0);
    applyStimulus(1'b0, BASE, 1'b1, 12'h042);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, STAT, 1'b0, 12'o0);
    applyStimulus(1'b0, BASE, 1'b1, 12'h043);
    applyStimulus(1'b0, STAT, 1'b0, 12'o0);
    if (data_out[2] !== (CAP == 1)) begin errors++; $display("FAIL overrun_set got=%b exp=%b", data_out[2], CAP == 1); end
    checks++;
    applyStimulus(1'b0, STAT, 1'b1, 12'o7777);
    if (data_out[2] !== 1'b0) begin errors++; $display("FAIL overrun_clear got=%b exp=0", data_out[2]); end
    checks++;
    for (int i = 0; i < 130; i++) begin
      applyStimulus(1'b0, STAT, 1'b0, 12'o0);
      if (tx !== exp_tx) begin errors++; $display("FAIL overrun_tx edge=%0d got=%b exp=%b", n, tx, exp_tx); end
      checks++;
    end
    if (data_out !== 12'o0001) begin errors++; $display("FAIL overrun_drained got=%o exp=0001", data_out); end
    checks++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, BASE, 1'b1, 12'(8'h31 + i));
    for (int i = 0; i < 220; i++) begin
      applyStimulus(1'b0, STAT, 1'b0, 12'o0);
      if (tx !== exp_tx) begin errors++; $display("FAIL b2b_tx edge=%0d got=%b exp=%b", n, tx, exp_tx); end
      checks++;
      if (data_out !== exp_dout(addr)) begin
        errors++; $display("FAIL b2b_status edge=%0d got=%o exp=%o", n, data_out, exp_dout(addr));
      end
      checks++;
    end
    applyStimulus(1'b0, STAT, 1'b1, 12'o0);
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b0, BASE, 1'b1, 12'h0A5);
    for (int i = 0; i < 4 * D + 2; i++) applyStimulus(1'b0, STAT, 1'b0, 12'o0);
    applyStimulus(1'b1, STAT, 1'b0, 12'o0);
    if (tx !== 1'b1) begin errors++; $display("FAIL midreset_tx got=%b exp=1", tx); end
    checks++;
    if (data_out !== 12'o0001) begin errors++; $display("FAIL midreset_status got=%o exp=0001", data_out); end
    checks++;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0, STAT, 1'b0, 12'o0);
      if (tx !== 1'b1) begin errors++; $display("FAIL midreset_resume edge=%0d got=%b exp=1", n, tx); end
      checks++;
    end
  endtask

  task automatic test_random();
    logic [8:0]  a;
    logic        w, r;
    logic [11:0] d;
    for (int i = 0; i < 900; i++) begin
      case ($urandom_range(0, 3))
        0: a = BASE;
        1: a = STAT;
        2: a = LEDS;
        default: a = 9'($urandom);
      endcase
      w = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 299) == 0);
      d = 12'($urandom);
      applyStimulus(r, a, w, d);
      if (tx !== exp_tx) begin errors++; $display("FAIL rand_tx edge=%0d got=%b exp=%b", n, tx, exp_tx); end
      checks++;
      if (data_out !== exp_dout(a)) begin
        errors++; $display("FAIL rand_dout edge=%0d addr=%o got=%o exp=%o", n, a, data_out, exp_dout(a));
      end
      checks++;
      if (hit !== (a == BASE || a == STAT)) begin errors++; $display("FAIL rand_hit addr=%o got=%b", a, hit); end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_frame(12'o0125);
    test_frame(12'o7777);
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simplez_uart_tx.md
Name: simplez_uart_tx

Overview:
Memory-mapped serial transmitter. It is a bus responder on the Simplez external memory bus, the target-side counterpart of the CPU's RA/esc/lec initiator. The CPU writes a byte with ST to the data register; the block serialises it as 8N1 on the tx pin. The CPU polls the status register with LD to know when it may write again. The top level muxes data_out onto the CPU data bus whenever hit is asserted.

Parameters:
ADDRW, 9, bus address width (matches CPU RA)
DATAW, 12, bus data width (matches CPU AC/RI)
BASE, 9'o101, address of TXDATA; STATUS is at BASE+1
CLKDIV, 104, clk cycles per bit (12 MHz / 115200), legal range 2..4095

Ports:
clk  in  1  system clock; all registers update on falling edge, same as CPU core
rst  in  1  synchronous reset, active-high
addr  in  ADDRW  address from CPU RA
wr  in  1  write strobe (CPU esc)
rd  in  1  read strobe (CPU lec)
data_in  in  DATAW  CPU data bus
data_out  out  DATAW  read data for STATUS/TXDATA
hit  out  1  addr matches BASE or BASE+1 (combinational)
tx  out  1  serial line, idle high

Behaviour:
- Reset (rst=1 at falling edge): tx=1, FSM=IDLE, holding register empty, overrun=0, baud counter=0. data_out and hit are combinational and reflect reset state immediately.
- hit = (addr==BASE)||(addr==BASE+1). data_out = 0 when hit=0.
- STATUS read value: {DATAW-3 zeros, overrun, busy, ready}.
  - ready: a write is accepted now.
  - busy: FSM not IDLE or data pending.
  - overrun: sticky bit.
- TXDATA read returns 0. rd has no side effects; reads are purely combinational on addr.
- Write to TXDATA (wr=1, addr==BASE), sampled on falling edge:
  - ready=1: latch data_in[7:0]; data_in[11:8] ignored.
  - ready=0: data dropped, overrun<=1.
- Write to STATUS (any value) clears overrun. Overrun set and clear in the same cycle cannot occur (different addresses).
- Holding register without FIFO: ready = holding empty. FSM in IDLE with holding full moves holding into the shift register next edge, holding becomes empty, FSM->START.
- FSM states and transitions:
  - IDLE: tx=1.
  - START: tx=0 for CLKDIV cycles, then DATA.
  - DATA: 8 bits LSB first, CLKDIV cycles each; 3-bit bit index wraps 7->0, then STOP.
  - STOP: tx=1 for CLKDIV cycles. Then IDLE, or directly START if data pending (back-to-back frames, no extra idle cycle).
- Baud counter: counts 0..CLKDIV-1, reloads to 0 on every state entry, tick at CLKDIV-1.
- Latency: write edge -> tx falls 2 falling edges later when idle. Frame = 10*CLKDIV cycles.
- Write accepted during the STOP bit: frame continues unaffected; the new byte starts after STOP.
- rst mid-frame: tx returns to 1 on that edge and pending data is discarded.

Optional Feature:
- Macro: SIMPLEZ_UART_TX_FIFO_EN.
- Defined: the holding register is replaced by a 4-entry FIFO (2-bit pointers, wrap-around, 3-bit count). ready = count<4; busy also set when count>0. Simultaneous write and pop when full: the pop happens, and the write is still rejected because ready was 0 at sample time.
- Undefined: single holding register as above. The STATUS layout is identical in both builds.

Decomposition:
- Shared package simplez_pkg:
  - ADDRW/DATAW constants.
  - Peripheral address constants (LEDS 9'o100, UART_TX 9'o101).
  - STATUS bit indices (READY=0, BUSY=1, OVERRUN=2).
  - FSM state encoding (IDLE, START, DATA, STOP).
- One natural sub-module: simplez_baud_gen (counter with reload input and tick output, parameter CLKDIV).

Test Plan:
- Reset, CLKDIV=4, idle 20 cycles -> tx=1 throughout; STATUS read = 12'o0001.
- Write 12'o0125 (0x55) to BASE -> tx sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; busy=1 during frame; STATUS=12'o0001 after 40 cycles.
- Write 12'o7777 -> frame carries 0xFF only, upper bits ignored; tx low for the start bit only.
- No-FIFO build: write 0x41, then 0x42 next cycle, then 0x43 mid-frame -> 0x41 and 0x42 sent back-to-back; 0x43 dropped; STATUS bit2=1; any write to BASE+1 clears it -> STATUS=12'o0001 after drain.
- FIFO build: 5 consecutive writes 0x31..0x35 with no waiting between them -> 0x31..0x34 sent in order (0x31 enters the shifter and frees a slot), then 0x35 sent; overrun=0 only if the 5th write follows the first pop, otherwise overrun=1 and 0x35 dropped; check against a model.
- Assert rst during bit 3 of a frame -> tx=1 on the next falling edge, STATUS=12'o0001; the byte does not resume.
